// File: rtl/pu_or1k_pcu_sampler.sv
// SPR-bus master that sweeps the PCCR performance counters on a programmable
// interval and streams per-interval deltas to a valid/ready sink.
module pu_or1k_pcu_sampler #(
    parameter int unsigned OPTION_PERFCOUNTERS_NUM = 7,
    parameter int unsigned INTERVAL_WIDTH          = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable_i,
    input  logic [INTERVAL_WIDTH-1:0]          interval_i,
    input  logic [OPTION_PERFCOUNTERS_NUM:0]   mask_i,
    input  logic                               spr_gnt_i,
    output logic                               spr_access_o,
    output logic                               spr_re_o,
    output logic                               spr_we_o,
    output logic [15:0]                        spr_addr_o,
    input  logic                               spr_bus_ack_i,
    input  logic [31:0]                        spr_dat_i,
    output logic                               sample_valid_o,
    output logic [2:0]                         sample_idx_o,
    output logic [31:0]                        sample_delta_o,
    input  logic                               sample_ready_i,
    output logic                               overrun_o,
    input  logic                               overrun_clr_i,
    output logic                               busy_o
);

    localparam int unsigned NCNT = OPTION_PERFCOUNTERS_NUM + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [2:0]                  idx_q, idx_d;
    logic [NCNT-1:0]             sweep_mask_q, sweep_mask_d;
    logic [31:0]                 delta_q, delta_d;
    logic [31:0]                 prev_q [NCNT];
    logic [31:0]                 prev_d [NCNT];
    logic [INTERVAL_WIDTH-1:0]   cnt_q, cnt_d;
    logic                        load_q, load_d;
    logic                        overrun_q, overrun_d;
    logic                        abort_q, abort_d;

    logic [INTERVAL_WIDTH-1:0]   cnt_cur;
    logic                        tick;
    logic [NCNT-1:0]             rem_mask;

    // Lowest set index of a counter mask (0 when the mask is empty).
    function automatic logic [2:0] lowest_set(input logic [NCNT-1:0] m);
        logic [2:0] r;
        logic       found;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NCNT; i++) begin
            if (m[i] && !found) begin
                r     = i[2:0];
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Interval timer. load_q marks "counter equals interval_i": it lets the
    // reset and disabled states track interval_i live without an async load
    // of a non-constant value.
    always_comb begin
        cnt_cur = load_q ? interval_i : cnt_q;
        tick    = 1'b0;
        cnt_d   = cnt_cur;
        load_d  = load_q;
        if (!enable_i) begin
            cnt_d  = interval_i;
            load_d = 1'b1;
        end else if (cnt_cur == '0) begin
            tick   = 1'b1;
            cnt_d  = interval_i;
            load_d = 1'b0;
        end else begin
            cnt_d  = cnt_cur - INTERVAL_WIDTH'(1);
            load_d = 1'b0;
        end
    end

    // Sweep sequencing, delta capture, previous-value tracking and overrun.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        sweep_mask_d = sweep_mask_q;
        delta_d      = delta_q;
        abort_d      = abort_q;
        overrun_d    = overrun_q;
        for (int unsigned k = 0; k < NCNT; k++) begin
            prev_d[k] = prev_q[k];
        end
        rem_mask = sweep_mask_q & ~(NCNT'(1) << idx_q);

        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (tick && (mask_i != '0)) begin
                    sweep_mask_d = mask_i;
                    idx_d        = lowest_set(mask_i);
                    state_d      = REQ;
                end
            end
            REQ: begin
                // A disable during the read never aborts the bus cycle; it
                // only marks the returned data for discard.
                if (!enable_i) begin
                    abort_d = 1'b1;
                end
                if (spr_gnt_i && spr_bus_ack_i) begin
                    if (abort_q || !enable_i) begin
                        abort_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        delta_d       = spr_dat_i - prev_q[idx_q];
                        prev_d[idx_q] = spr_dat_i;
                        state_d       = OUT;
                    end
                end
            end
            OUT: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (sample_ready_i) begin
                    sweep_mask_d = rem_mask;
                    if (rem_mask != '0) begin
                        idx_d   = lowest_set(rem_mask);
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!enable_i) begin
            for (int unsigned k = 0; k < NCNT; k++) begin
                prev_d[k] = '0;
            end
        end

        if (tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end else if (overrun_clr_i) begin
            overrun_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            sweep_mask_q <= '0;
            delta_q      <= '0;
            cnt_q        <= '0;
            load_q       <= 1'b1;
            overrun_q    <= 1'b0;
            abort_q      <= 1'b0;
            for (int unsigned k = 0; k < NCNT; k++) begin
                prev_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            sweep_mask_q <= sweep_mask_d;
            delta_q      <= delta_d;
            cnt_q        <= cnt_d;
            load_q       <= load_d;
            overrun_q    <= overrun_d;
            abort_q      <= abort_d;
            for (int unsigned k = 0; k < NCNT; k++) begin
                prev_q[k] <= prev_d[k];
            end
        end
    end

    // Outputs decode straight from state so reset clears them immediately.
    always_comb begin
        spr_access_o   = (state_q == REQ);
        spr_re_o       = (state_q == REQ);
        spr_we_o       = 1'b0;
        spr_addr_o     = (state_q == REQ) ? {13'h0700, idx_q} : '0;
        sample_valid_o = (state_q == OUT);
        sample_idx_o   = (state_q == OUT) ? idx_q : '0;
        sample_delta_o = (state_q == OUT) ? delta_q : '0;
        overrun_o      = overrun_q;
        busy_o         = (state_q != IDLE);
    end

endmodule

// File: doc/pu_or1k_pcu_sampler.md
Name: pu_or1k_pcu_sampler

Overview:
SPR-bus master that periodically sweeps the performance counter registers PCCR0..PCCRn and streams each counter's per-interval delta to a trace/profiling sink over valid/ready.
- Sits beside the PCU on the shared SPR bus.
- Requests the bus through an external arbiter grant, so CPU SPR accesses keep priority.
- Software programs enable, interval and counter mask; the block does all sequencing, delta arithmetic and overrun detection.

Parameters:
OPTION_PERFCOUNTERS_NUM, 7, index of the highest counter; counters 0..OPTION_PERFCOUNTERS_NUM exist (max 7).
INTERVAL_WIDTH, 16, width of the sample-interval reload value.

Ports:
clk  input  1  clock.
rst  input  1  asynchronous active-low reset.
enable_i  input  1  sampling enable.
interval_i  input  INTERVAL_WIDTH  reload value; tick period is interval_i+1 cycles.
mask_i  input  OPTION_PERFCOUNTERS_NUM+1  counters to sample; bit k selects PCCRk.
spr_gnt_i  input  1  arbiter grant of the shared SPR bus.
spr_access_o  output  1  SPR request.
spr_re_o  output  1  read strobe, equal to spr_access_o.
spr_we_o  output  1  constant 0; the block never writes.
spr_addr_o  output  16  0x3800 + counter index (PCCRk).
spr_bus_ack_i  input  1  SPR acknowledge.
spr_dat_i  input  32  SPR read data.
sample_valid_o  output  1  sample available.
sample_idx_o  output  3  counter index of the sample.
sample_delta_o  output  32  counter delta since the previous sample of that index.
sample_ready_i  input  1  sink accepts the sample.
overrun_o  output  1  sticky: a tick arrived while a sweep was in progress.
overrun_clr_i  input  1  clears overrun_o.
busy_o  output  1  sweep in progress (state != IDLE).

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; spr_addr_o=0; interval counter=interval_i; prev[0..N]=0; overrun_o=0.
- Interval timer:
  - While enable_i=0: counter is held at interval_i, no ticks.
  - While enable_i=1: counter decrements; a tick fires in the cycle count==0 and the counter reloads interval_i.
  - First tick occurs interval_i+1 cycles after enable_i rises. interval_i=0 gives a tick every cycle.
- prev[] is cleared to 0 in every cycle enable_i=0, so the first delta after enabling equals the raw counter value.
- FSM states: IDLE, REQ, OUT.
  - IDLE: on tick with mask_i != 0, latch the mask into sweep_mask and go to REQ on the lowest set index. A tick with mask_i==0 is ignored.
  - REQ: assert spr_access_o/spr_re_o with spr_addr_o=0x3800+idx. Hold all three stable until a cycle with spr_gnt_i & spr_bus_ack_i.
    - In that cycle: capture delta = spr_dat_i - prev[idx] (mod 2^32, so counter wrap yields the correct difference), set prev[idx]=spr_dat_i, deassert the request next cycle, go to OUT.
    - Minimum SPR latency is 1 cycle (ack in the first request cycle).
  - OUT: sample_valid_o=1, with sample_idx_o/sample_delta_o stable until sample_valid_o & sample_ready_i.
    - On that handshake, clear the bit in sweep_mask.
    - Go to REQ for the next set bit, else to IDLE.
  - One sample is outstanding at a time; no buffering.
- Mask changes mid-sweep do not affect the current sweep, which uses the latched sweep_mask.
- Overrun:
  - A tick while state != IDLE sets overrun_o and the tick is dropped; no queued sweep.
  - overrun_clr_i clears overrun_o. If a tick-overrun and overrun_clr_i occur in the same cycle, set wins.
- Disable mid-sweep (enable_i falls):
  - In REQ: the request is held until ack (the SPR transaction is never aborted), the data is discarded, then IDLE.
  - In OUT: sample_valid_o drops the next cycle and the FSM returns to IDLE. This is the only case where valid deasserts without ready.
- Reset mid-operation: asynchronous return to the reset state; any SPR request is dropped immediately.

Test Plan:
- Reset, then enable=1, interval_i=3, mask=0x01; the bus acks in the first request cycle with 0x00000010 → a tick on cycle 4 after enable, a read of addr 0x3800, and a sample idx=0, delta=0x10. The next sweep reads 0x25 → delta=0x15.
- Wrap: prev[2]=0xFFFFFFF0 and the next read returns 0x00000005 → delta=0x00000015.
- mask=0x85, spr_gnt_i low for 5 cycles, sample_ready_i low for 3 cycles → reads 0x3800, 0x3802, 0x3807 in order. Request signals stay stable through the wait, and the sample is held stable until ready.
- interval_i=0, mask=0xFF, ready held low → overrun_o=1 on the second tick and only one sweep is in flight. overrun_clr_i asserted in a non-tick cycle clears it; asserted in the same cycle as an overrun tick, overrun_o stays 1.
- enable_i dropped while in REQ → the request is held until ack, then IDLE with no sample_valid_o. Re-enabling gives delta equal to the raw value (prev cleared).
- rst asserted during OUT → all outputs 0 immediately, asynchronously, with no clock edge required.
